dm_cache_ctrl: RTL and testbench
================================

# dm_cache_ctrl

Read-only direct-mapped cache with its controller. It holds the tag, valid and data arrays, does the hit/miss lookup and returns hits one cycle after acceptance. On a miss it sequences a burst line refill from main memory. It sits between the CPU load port and the main-memory read port and replaces the purely combinational cache lookup with a handshaked, refill-capable block.

## Interface
Parameters:
- `LINES`, 16: number of cache lines; power of two, ≥2.
- `WORDS`, 4: 32-bit words per line; power of two, ≥2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU read request.
- `cpu_addr`  in  32  byte address; bits [1:0] ignored.
- `cpu_ready`  out  1  request accepted on an edge where `cpu_req && cpu_ready`.
- `cpu_rvalid`  out  1  one-cycle pulse; response data valid.
- `cpu_rdata`  out  32  response word.
- `cpu_hit`  out  1  with `cpu_rvalid`: 1 = hit, 0 = miss.
- `flush`  in  1  invalidate all lines (pulse or level).
- `mem_req`  out  1  one-cycle line-fetch request.
- `mem_addr`  out  32  line-aligned fetch address.
- `mem_rvalid`  in  1  refill beat valid.
- `mem_rdata`  in  32  refill beat data; beats arrive in ascending word order.

## Operation
- Address split: [1:0] byte, next log2(WORDS) bits word offset, next log2(LINES) bits index, remaining high bits tag.
- FSM states: IDLE, MISS_REQ, REFILL, RESP.
- IDLE:
  - `cpu_ready`=1 unless a flush is pending or asserted.
  - On accept, compare tag and valid combinationally against `cpu_addr`.
  - Hit: the word is registered to `cpu_rdata`, and the FSM stays in IDLE. Back-to-back hits run at 1/cycle.
  - Miss: latch the address and go to MISS_REQ.
- MISS_REQ: `mem_req`=1 for exactly one cycle, with `mem_addr` = {tag, index, zeros}. Then go to REFILL.
- REFILL:
  - Each `mem_rvalid` writes `mem_rdata` into data[index][beat], and the beat counter increments.
  - The beat whose number equals the latched word offset is captured for the response.
  - On beat WORDS-1, write the tag, set valid, and go to RESP.
- RESP: `cpu_rvalid`=1, `cpu_hit`=0, `cpu_rdata` = captured word. Then go to IDLE.
- `mem_rvalid` outside REFILL is ignored.
- Flush:
  - Clears all valid bits in one cycle, only while in IDLE.
  - If `flush` arrives while busy, it is latched and executed on the first IDLE cycle, before any new accept.
  - If `flush` and `cpu_req` occur in the same IDLE cycle, flush wins; the request is not accepted (`cpu_ready`=0).
- Reset values:
  - FSM = IDLE, all valid bits = 0, pending flush = 0, beat counter = 0.
  - `cpu_ready`=1, `cpu_rvalid`=0, `cpu_hit`=0, `cpu_rdata`=0, `mem_req`=0, `mem_addr`=0.
  - Tag and data arrays are not reset.
- Reset mid-refill aborts: the line stays invalid, and further beats are ignored.

## Timing
- Hit: accept at edge k; `cpu_rvalid`/`cpu_hit`=1 during cycle k+1.
- Miss:
  - Accept at edge k; `mem_req` high during cycle k+1.
  - Beats come any number of cycles later, with gaps allowed.
  - `cpu_rvalid` is high in the cycle after the edge that samples the last beat.
- `cpu_ready`=0 from the cycle after a miss accept through RESP. It returns to 1 in the cycle after RESP.
- The hit-path `cpu_rvalid` and the RESP `cpu_rvalid` never overlap.

## Configuration
- `DM_CACHE_STATS_EN` defined:
  - Adds outputs `hit_count` [31:0] and `miss_count` [31:0].
  - Each increments on the `cpu_rvalid` pulse of its kind and saturates at 0xFFFFFFFF.
  - Both reset to 0 and are not cleared by `flush`.
- Not defined: no counters and no ports; behaviour is otherwise identical.

## Test plan
Defaults LINES=16, WORDS=4. The memory model returns word address as data, with latency 2 and no gaps.
- Cold read 0x14 → `mem_req` with `mem_addr`=0x10, 4 beats, then `cpu_rvalid`, `cpu_hit`=0, `cpu_rdata`=0x14.
- Repeat 0x14 → `cpu_rvalid` one cycle after accept, `cpu_hit`=1, `cpu_rdata`=0x14, no `mem_req`.
- Conflict miss and re-miss (index 1 in both cases):
  - Read 0x216 → miss, `mem_addr`=0x210, `cpu_rdata`=0x214.
  - Then read 0x16 → miss again, `cpu_rdata`=0x14.
- Flush during a REFILL of 0x14:
  - The refill completes with a miss response.
  - Flush executes next, and `cpu_ready`=0 for that cycle.
  - A following read of 0x14 misses.
- Reset mid-REFILL after 2 beats:
  - Outputs go to reset values immediately.
  - The remaining beats are ignored.
  - Read 0x14 misses.
- With `DM_CACHE_STATS_EN`, running the first three scenarios → `hit_count`=1, `miss_count`=3.

Source files
------------

// File: rtl/dm_cache_ctrl.sv
// Read-only direct-mapped cache with hit/miss lookup and burst line refill.
// Optional hit/miss statistics counters are enabled by defining DM_CACHE_STATS_EN.
module dm_cache_ctrl #(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic        cpu_ready,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    output logic        cpu_hit,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
`ifdef DM_CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned WB    = $clog2(WORDS);
    localparam int unsigned IB    = $clog2(LINES);
    localparam int unsigned TAG_W = 32 - 2 - WB - IB;

    typedef enum logic [1:0] {IDLE, MISS_REQ, REFILL, RESP} state_t;

    state_t state, state_n;

    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES][WORDS];
    logic [LINES-1:0] valid;

    logic [WB-1:0]    req_word;
    logic [IB-1:0]    req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             lookup_hit;

    logic [TAG_W-1:0] lat_tag;
    logic [IB-1:0]    lat_idx;
    logic [WB-1:0]    lat_word;
    logic [WB-1:0]    beat;
    logic [31:0]      capt;
    logic             flush_pend;

    logic accept, do_flush, beat_we, last_beat;
    logic addr_unused;

    assign req_word    = cpu_addr[2 +: WB];
    assign req_idx     = cpu_addr[2 + WB +: IB];
    assign req_tag     = cpu_addr[31 -: TAG_W];
    assign lookup_hit  = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign addr_unused = ^cpu_addr[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        cpu_ready = 1'b0;
        mem_req   = 1'b0;
        accept    = 1'b0;
        do_flush  = 1'b0;
        beat_we   = 1'b0;
        last_beat = 1'b0;
        case (state)
            IDLE: begin
                // A pending or live flush takes the IDLE cycle and blocks acceptance.
                if (flush || flush_pend) begin
                    do_flush = 1'b1;
                end else begin
                    cpu_ready = 1'b1;
                    if (cpu_req) begin
                        accept = 1'b1;
                        if (!lookup_hit) state_n = MISS_REQ;
                    end
                end
            end
            MISS_REQ: begin
                mem_req = 1'b1;
                state_n = REFILL;
            end
            REFILL: begin
                if (mem_rvalid) begin
                    beat_we = 1'b1;
                    if (beat == WB'(WORDS - 1)) begin
                        last_beat = 1'b1;
                        state_n   = RESP;
                    end
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid      <= '0;
            flush_pend <= 1'b0;
            beat       <= '0;
            capt       <= '0;
            lat_tag    <= '0;
            lat_idx    <= '0;
            lat_word   <= '0;
            cpu_rvalid <= 1'b0;
            cpu_hit    <= 1'b0;
            cpu_rdata  <= '0;
            mem_addr   <= '0;
        end else begin
            cpu_rvalid <= 1'b0;
            cpu_hit    <= 1'b0;

            if (do_flush)   flush_pend <= 1'b0;
            else if (flush) flush_pend <= 1'b1;

            if (do_flush)       valid          <= '0;
            else if (last_beat) valid[lat_idx] <= 1'b1;

            if (accept && lookup_hit) begin
                cpu_rvalid <= 1'b1;
                cpu_hit    <= 1'b1;
                cpu_rdata  <= data_mem[req_idx][req_word];
            end
            if (accept && !lookup_hit) begin
                lat_tag  <= req_tag;
                lat_idx  <= req_idx;
                lat_word <= req_word;
                beat     <= '0;
                mem_addr <= {req_tag, req_idx, {(WB + 2){1'b0}}};
            end

            if (beat_we) begin
                beat <= beat + 1'b1;
                if (beat == lat_word) capt <= mem_rdata;
            end
            // The requested word may be the final beat itself, so bypass capt then.
            if (last_beat) begin
                cpu_rvalid <= 1'b1;
                cpu_rdata  <= (beat == lat_word) ? mem_rdata : capt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (beat_we)   data_mem[lat_idx][beat] <= mem_rdata;
        if (last_beat) tag_mem[lat_idx]        <= lat_tag;
    end

`ifdef DM_CACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (cpu_rvalid) begin
            if (cpu_hit && hit_count != '1)    hit_count  <= hit_count + 1'b1;
            if (!cpu_hit && miss_count != '1)  miss_count <= miss_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed self-checking bench for dm_cache_ctrl (LINES=16, WORDS=4).
// Memory model returns the byte address of each word, latency 2, no gaps.
module tb_dm_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic        cpu_ready, cpu_rvalid, cpu_hit;
    logic [31:0] cpu_rdata;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
`ifdef DM_CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int vectors = 0;
    int miscompares = 0;
    int mreq_cnt = 0;
    int rv_cnt = 0;
    logic [31:0] last_maddr = '0;
    logic model_busy = 1'b0;

    always #5 clk = ~clk;

    dm_cache_ctrl #(.LINES(16), .WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
        .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef DM_CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    initial begin
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                mreq_cnt++;
                last_maddr = mem_addr;
                model_busy = 1'b1;
                @(negedge clk);
                for (int i = 0; i < 4; i++) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = last_maddr + 32'(4 * i);
                    @(negedge clk);
                end
                mem_rvalid = 1'b0;
                model_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) if (cpu_rvalid === 1'b1) rv_cnt++;

    task automatic wait_ready(input string nm);
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (cpu_ready !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (cpu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ready_timeout: cpu_ready=%b expected 1", nm, cpu_ready);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic exp_hit,
                           input logic [31:0] exp_data, input logic [31:0] exp_maddr,
                           input string nm);
        int cyc, m0;
        bit ready_bad;
        wait_ready(nm);
        m0 = mreq_cnt;
        cpu_req = 1'b1;
        cpu_addr = addr;
        @(negedge clk);
        cpu_req = 1'b0;
        cyc = 1;
        ready_bad = 1'b0;
        while (cpu_rvalid !== 1'b1 && cyc < 50) begin
            if (cpu_ready !== 1'b0) ready_bad = 1'b1;
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (cpu_rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s rvalid_timeout: cpu_rvalid=%b expected 1", nm, cpu_rvalid);
        end
        vectors++;
        if (cpu_hit !== exp_hit) begin
            miscompares++;
            $display("FAIL %s hit: got %b expected %b", nm, cpu_hit, exp_hit);
        end
        vectors++;
        if (cpu_rdata !== exp_data) begin
            miscompares++;
            $display("FAIL %s rdata: got %h expected %h", nm, cpu_rdata, exp_data);
        end
        vectors++;
        if (cyc !== (exp_hit ? 1 : 6)) begin
            miscompares++;
            $display("FAIL %s latency: got %0d expected %0d", nm, cyc, exp_hit ? 1 : 6);
        end
        vectors++;
        if (mreq_cnt - m0 !== (exp_hit ? 0 : 1)) begin
            miscompares++;
            $display("FAIL %s mem_req_count: got %0d expected %0d", nm, mreq_cnt - m0, exp_hit ? 0 : 1);
        end
        if (!exp_hit) begin
            vectors++;
            if (last_maddr !== exp_maddr) begin
                miscompares++;
                $display("FAIL %s mem_addr: got %h expected %h", nm, last_maddr, exp_maddr);
            end
            vectors++;
            if (ready_bad) begin
                miscompares++;
                $display("FAIL %s ready_during_miss: got 1 expected 0", nm);
            end
        end
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({cpu_ready, cpu_rvalid, cpu_hit, mem_req} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 1000", {cpu_ready, cpu_rvalid, cpu_hit, mem_req});
        end
        vectors++;
        if (cpu_rdata !== 32'h0 || mem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data: rdata=%h mem_addr=%h expected 0", cpu_rdata, mem_addr);
        end
`ifdef DM_CACHE_STATS_EN
        vectors++;
        if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_stats: hit=%0d miss=%0d expected 0", hit_count, miss_count);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_cold_and_hit();
        do_read(32'h14, 1'b0, 32'h14, 32'h10, "cold_0x14");
        do_read(32'h14, 1'b1, 32'h14, 32'h0,  "repeat_0x14");
    endtask

    task automatic test_conflict();
        do_read(32'h216, 1'b0, 32'h214, 32'h210, "conflict_0x216");
        do_read(32'h16,  1'b0, 32'h14,  32'h10,  "remiss_0x16");
`ifdef DM_CACHE_STATS_EN
        @(negedge clk);
        vectors++;
        if (hit_count !== 32'd1 || miss_count !== 32'd3) begin
            miscompares++;
            $display("FAIL stats: hit=%0d miss=%0d expected 1 3", hit_count, miss_count);
        end
`endif
    endtask

    task automatic test_back_to_back();
        wait_ready("b2b");
        cpu_req = 1'b1;
        cpu_addr = 32'h14;
        @(negedge clk);
        vectors++;
        if ({cpu_rvalid, cpu_hit, cpu_ready} !== 3'b111 || cpu_rdata !== 32'h14) begin
            miscompares++;
            $display("FAIL b2b_first: vhr=%b rdata=%h expected 111 00000014", {cpu_rvalid, cpu_hit, cpu_ready}, cpu_rdata);
        end
        cpu_addr = 32'h18;
        @(negedge clk);
        cpu_req = 1'b0;
        vectors++;
        if ({cpu_rvalid, cpu_hit} !== 2'b11 || cpu_rdata !== 32'h18) begin
            miscompares++;
            $display("FAIL b2b_second: vh=%b rdata=%h expected 11 00000018", {cpu_rvalid, cpu_hit}, cpu_rdata);
        end
    endtask

    task automatic test_flush_idle();
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_addr = 32'h14;
        flush = 1'b1;
        #1;
        vectors++;
        if (cpu_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_wins_ready: got %b expected 0", cpu_ready);
        end
        @(negedge clk);
        flush = 1'b0;
        cpu_req = 1'b0;
        vectors++;
        if (cpu_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_wins_noaccept: rvalid=%b expected 0", cpu_rvalid);
        end
        do_read(32'h14, 1'b0, 32'h14, 32'h10, "after_idle_flush");
    endtask

    task automatic test_flush_refill();
        int cyc;
        pulse_flush();
        wait_ready("flush_refill");
        cpu_req = 1'b1;
        cpu_addr = 32'h14;
        @(negedge clk);
        cpu_req = 1'b0;
        cyc = 0;
        while (mem_rvalid !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        cyc = 0;
        while (cpu_rvalid !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if ({cpu_rvalid, cpu_hit} !== 2'b10 || cpu_rdata !== 32'h14) begin
            miscompares++;
            $display("FAIL flush_refill_resp: vh=%b rdata=%h expected 10 00000014", {cpu_rvalid, cpu_hit}, cpu_rdata);
        end
        @(negedge clk);
        vectors++;
        if (cpu_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_exec_ready: got %b expected 0", cpu_ready);
        end
        @(negedge clk);
        vectors++;
        if (cpu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_after_ready: got %b expected 1", cpu_ready);
        end
        do_read(32'h14, 1'b0, 32'h14, 32'h10, "after_refill_flush");
    endtask

    task automatic test_reset_refill();
        int cyc, cnt, rv0;
        pulse_flush();
        wait_ready("reset_refill");
        cpu_req = 1'b1;
        cpu_addr = 32'h14;
        @(negedge clk);
        cpu_req = 1'b0;
        cyc = 0;
        cnt = 0;
        while (cnt < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (mem_rvalid === 1'b1) cnt++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({cpu_ready, cpu_rvalid, cpu_hit, mem_req} !== 4'b1000) begin
            miscompares++;
            $display("FAIL midreset_ctrl: got %b expected 1000", {cpu_ready, cpu_rvalid, cpu_hit, mem_req});
        end
        vectors++;
        if (cpu_rdata !== 32'h0 || mem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL midreset_data: rdata=%h mem_addr=%h expected 0", cpu_rdata, mem_addr);
        end
        rv0 = rv_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        while (model_busy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        vectors++;
        if (rv_cnt !== rv0) begin
            miscompares++;
            $display("FAIL midreset_beats_ignored: rvalid pulses=%0d expected 0", rv_cnt - rv0);
        end
        do_read(32'h14, 1'b0, 32'h14, 32'h10, "after_midreset");
    endtask

    initial begin
        test_reset();
        test_cold_and_hit();
        test_conflict();
        test_back_to_back();
        test_flush_idle();
        test_flush_refill();
        test_reset_refill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
